sweep_check_ctrl: RTL and testbench

SWEEP_CHECK_CTRL -- requirements
Module: sweep_check_ctrl

---
 rtl/sweep_check_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sweep_check_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_check_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sweep_check_ctrl
// Description : Exhaustive 4-bit equivalence sweep controller. Drives every
//               vector 0..15 on Xout to two implementations, waits SETTLE
//               cycles per vector, compares fa against fb and records the
//               mismatch count, the lowest failing vector and a pass flag.
// Ports       : clk          - clock, rising edge
//               reset        - synchronous active-high reset
//               start        - launch a sweep (honoured in IDLE only)
//               abort        - cancel a running sweep
//               fa, fb       - outputs of implementations A and B
//               Xout         - registered vector applied to both
//               busy         - high outside IDLE
//               done         - one-cycle pulse when a full sweep completes
//               mismatch_cnt - vectors with fa != fb
//               first_bad    - lowest mismatching vector
//               first_valid  - first_bad holds a recorded mismatch
//               pass         - last sweep completed with no mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module sweep_check_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       fa,
    input  logic       fb,
    output logic [3:0] Xout,
    output logic       busy,
    output logic       done,
    output logic [4:0] mismatch_cnt,
    output logic [3:0] first_bad,
    output logic       first_valid,
    output logic       pass
);

    localparam logic [3:0] c_SETTLE_LD = 4'(SETTLE);
    localparam logic [3:0] c_X_LAST    = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // With no settle time the vector is sampled on the cycle it is applied.
    localparam state_t c_AFTER_LOAD = (c_SETTLE_LD == 4'd0) ? S_SAMPLE : S_SETTLE;

    state_t     r_state,    w_state_nxt;
    logic [3:0] r_xout,     w_xout_nxt;
    logic [3:0] r_timer,    w_timer_nxt;
    logic [4:0] r_cnt,      w_cnt_nxt;
    logic [3:0] r_fbad,     w_fbad_nxt;
    logic       r_fvalid,   w_fvalid_nxt;
    logic       r_pass,     w_pass_nxt;
    logic       w_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_xout   <= 4'd0;
            r_timer  <= 4'd0;
            r_cnt    <= 5'd0;
            r_fbad   <= 4'd0;
            r_fvalid <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_xout   <= w_xout_nxt;
            r_timer  <= w_timer_nxt;
            r_cnt    <= w_cnt_nxt;
            r_fbad   <= w_fbad_nxt;
            r_fvalid <= w_fvalid_nxt;
            r_pass   <= w_pass_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_xout_nxt   = r_xout;
        w_timer_nxt  = r_timer;
        w_cnt_nxt    = r_cnt;
        w_fbad_nxt   = r_fbad;
        w_fvalid_nxt = r_fvalid;
        w_pass_nxt   = r_pass;
        w_done       = 1'b0;

        case (r_state)
            S_IDLE: begin
                // abort has priority over start while idle
                if (start && !abort) begin
                    w_xout_nxt   = 4'd0;
                    w_cnt_nxt    = 5'd0;
                    w_fbad_nxt   = 4'd0;
                    w_fvalid_nxt = 1'b0;
                    w_pass_nxt   = 1'b0;
                    w_timer_nxt  = c_SETTLE_LD;
                    w_state_nxt  = c_AFTER_LOAD;
                end
            end

            S_SETTLE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_pass_nxt  = 1'b0;
                end else begin
                    // timer holds the remaining settle cycles including this one
                    w_timer_nxt = r_timer - 4'd1;
                    if (r_timer <= 4'd1) begin
                        w_state_nxt = S_SAMPLE;
                    end
                end
            end

            S_SAMPLE: begin
                if (abort) begin
                    // the compare of this cycle is deliberately dropped
                    w_state_nxt = S_IDLE;
                    w_pass_nxt  = 1'b0;
                end else begin
                    if (fa != fb) begin
                        w_cnt_nxt = r_cnt + 5'd1;
                        if (!r_fvalid) begin
                            w_fbad_nxt   = r_xout;
                            w_fvalid_nxt = 1'b1;
                        end
                    end
                    if (r_xout != c_X_LAST) begin
                        w_xout_nxt  = r_xout + 4'd1;
                        w_timer_nxt = c_SETTLE_LD;
                        w_state_nxt = c_AFTER_LOAD;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
                if (abort) begin
                    w_pass_nxt = 1'b0;
                end else begin
                    w_done     = 1'b1;
                    w_pass_nxt = (r_cnt == 5'd0);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign Xout         = r_xout;
    assign busy         = (r_state != S_IDLE);
    assign done         = w_done;
    assign mismatch_cnt = r_cnt;
    assign first_bad    = r_fbad;
    assign first_valid  = r_fvalid;
    assign pass         = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_sweep_check_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sweep_check_ctrl
// Description : Directed bench for sweep_check_ctrl. Two instances (SETTLE=1
//               and SETTLE=0) share clock and reset. Implementation outputs
//               are modelled from Xout with a per-vector disagreement mask;
//               expected sweep results are queued at launch and checked when
//               done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sweep_check_ctrl;

    logic clk;
    logic reset;
    logic start1, abort1, fa1, fb1;
    logic start0, abort0, fa0, fb0;
    logic [3:0] x1, x0, fbad1, fbad0;
    logic [4:0] cnt1, cnt0;
    logic busy1, done1, fv1, pass1;
    logic busy0, done0, fv0, pass0;
    logic [15:0] mask1, mask0;

    sweep_check_ctrl #(.SETTLE(1)) u_s1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .fa(fa1), .fb(fb1), .Xout(x1), .busy(busy1), .done(done1),
        .mismatch_cnt(cnt1), .first_bad(fbad1), .first_valid(fv1), .pass(pass1)
    );

    sweep_check_ctrl #(.SETTLE(0)) u_s0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .fa(fa0), .fb(fb0), .Xout(x0), .busy(busy0), .done(done0),
        .mismatch_cnt(cnt0), .first_bad(fbad0), .first_valid(fv0), .pass(pass0)
    );

    // Implementation models: A is parity of the vector, B disagrees where mask is set.
    always_comb begin
        fa1 = ^x1;
        fb1 = fa1 ^ mask1[x1];
        fa0 = ^x0;
        fb0 = fa0 ^ mask0[x0];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Selected-instance view used by the shared sweep task.
    bit         sel;
    logic [3:0] sx, sfbad;
    logic [4:0] scnt;
    logic       sbusy, sdone, sfv, spass;
    always_comb begin
        sx    = sel ? x1    : x0;
        sfbad = sel ? fbad1 : fbad0;
        scnt  = sel ? cnt1  : cnt0;
        sbusy = sel ? busy1 : busy0;
        sdone = sel ? done1 : done0;
        sfv   = sel ? fv1   : fv0;
        spass = sel ? pass1 : pass0;
    end

    typedef struct {
        logic [4:0] cnt;
        logic [3:0] fbad;
        logic       fv;
        logic       pass;
        int         lat;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full sweep on the selected instance with the given disagreement mask.
    task automatic run_sweep(input bit s, input logic [15:0] m);
        exp_t e, g;
        int   n, ex;
        bit   seen, stepbad;
        sel = s;
        if (s) mask1 = m; else mask0 = m;
        e.cnt  = 5'($countones(m));
        e.fv   = (m != 16'd0);
        e.pass = (m == 16'd0);
        e.fbad = 4'd0;
        for (int i = 15; i >= 0; i--) if (m[i]) e.fbad = 4'(i);
        e.lat  = s ? 32 : 16;
        sb.push_back(e);
        if (s) start1 = 1'b1; else start0 = 1'b1;
        tick();
        start1 = 1'b0;
        start0 = 1'b0;
        chk("start_busy", sbusy, 1);
        chk("start_xout", sx, 0);
        chk("start_cnt_clear", scnt, 0);
        chk("start_fv_clear", sfv, 0);
        n = 0; seen = 0; stepbad = 0;
        while (!seen && n < 100) begin
            tick();
            n++;
            ex = s ? n / 2 : n;
            if (ex > 15) ex = 15;
            if (sdone) seen = 1;
            if (sx !== 4'(ex)) stepbad = 1;
        end
        g = sb.pop_front();
        chk("done_latency", n, g.lat);
        chk("xout_step", stepbad, 0);
        chk("mismatch_cnt", scnt, g.cnt);
        chk("first_bad", sfbad, g.fbad);
        chk("first_valid", sfv, g.fv);
        tick();
        chk("done_one_cycle", sdone, 0);
        chk("pass", spass, g.pass);
        chk("idle_busy", sbusy, 0);
    endtask

    task automatic wait_x1(input logic [3:0] v, input string tag);
        int n;
        n = 0;
        while (x1 !== v && n < 200) begin
            tick();
            n++;
        end
        chk(tag, (n < 200), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        reset = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; start0 = 1'b0; abort0 = 1'b0;
        mask1 = 16'd0; mask0 = 16'd0; sel = 1'b1;
        tick(); tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("reset_state_s1", {x1, busy1, done1, cnt1, fbad1, fv1, pass1}, 0);
        chk("reset_state_s0", {x0, busy0, done0, cnt0, fbad0, fv0, pass0}, 0);

        // Equivalent implementations, then mismatches at 5 and 12.
        run_sweep(1'b1, 16'h0000);
        run_sweep(1'b1, 16'h1020);
        // Every vector differs with no settle time.
        run_sweep(1'b0, 16'hFFFF);
        chk("pass_after_fail_s0", pass0, 0);

        // abort and start together in IDLE: nothing starts, results held.
        start1 = 1'b1; abort1 = 1'b1;
        tick();
        start1 = 1'b0; abort1 = 1'b0;
        chk("abort_wins_busy", busy1, 0);
        chk("results_held_cnt", cnt1, 2);

        // Abort at vector 7 after one mismatch at vector 2.
        sel = 1'b1;
        mask1 = 16'h0004;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_x1(4'd7, "reach_x7");
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        chk("abort_busy", busy1, 0);
        chk("abort_partial_cnt", cnt1, 1);
        chk("abort_partial_fbad", fbad1, 2);
        chk("abort_pass", pass1, 0);
        ndone = 0;
        repeat (40) begin
            tick();
            if (done1) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_sweep(1'b1, 16'h8000);

        // Mid-run start is ignored, reset mid-sweep discards it.
        mask1 = 16'h0001;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_x1(4'd3, "reach_x3");
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("midrun_start_xout", x1, 3);
        wait_x1(4'd9, "reach_x9_after_start");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrun_reset_state", {x1, busy1, done1, cnt1, fbad1, fv1, pass1}, 0);
        ndone = 0;
        repeat (40) begin
            tick();
            if (done1) ndone++;
        end
        chk("reset_no_done", ndone, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
